// File: rtl/fp_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_addsub_seq                                                |
// | Description : Multi-cycle sequencer for the single-precision FP add/sub    |
// |               datapath (extract/align -> add/normalize -> round). Accepts  |
// |               one op at a time over valid/ready, resolves the effective    |
// |               rounding mode, pulses one stage enable per cycle and holds   |
// |               a tagged completion until writeback takes it.                |
// | Optional    : `define FP_ADDSUB_PERF_EN adds perf_ops / perf_stall.        |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               flush                 - kill in-flight op                    |
// |               req_valid/req_ready   - issue handshake                      |
// |               req_sub/req_rm/req_tag, frm - op controls, CSR rm            |
// |               align_en/addnorm_en/round_en - stage register enables        |
// |               op_sub/rm_eff         - latched datapath controls            |
// |               res_valid/res_ready/res_tag/res_illegal - completion         |
// |               busy, err_timeout     - status                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_addsub_seq #(
   parameter int TAG_W        = 5,
   parameter int HOLD_TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_sub,
   input  logic [2:0]       req_rm,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [2:0]       frm,
   output logic             align_en,
   output logic             addnorm_en,
   output logic             round_en,
   output logic             op_sub,
   output logic [2:0]       rm_eff,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_illegal,
   output logic             busy,
   output logic             err_timeout
`ifdef FP_ADDSUB_PERF_EN
   ,
   output logic [15:0]      perf_ops,
   output logic [15:0]      perf_stall
`endif
);

   localparam logic [2:0] c_S_IDLE    = 3'd0;
   localparam logic [2:0] c_S_ALIGN   = 3'd1;
   localparam logic [2:0] c_S_ADDNORM = 3'd2;
   localparam logic [2:0] c_S_ROUND   = 3'd3;
   localparam logic [2:0] c_S_HOLD    = 3'd4;

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [2:0]       w_rm_sel;
   logic             w_rm_legal;
   logic             w_accept;
   logic             w_stall;
   logic             r_op_sub;
   logic [2:0]       r_rm_eff;
   logic [TAG_W-1:0] r_res_tag;
   logic             r_res_illegal;

   // rm 111 in the instruction means "use the CSR"; anything above RMM
   // (including a CSR value of 111) is reserved and traps.
   assign w_rm_sel   = (req_rm == 3'b111) ? frm : req_rm;
   assign w_rm_legal = (w_rm_sel <= 3'b100);
   assign w_accept   = req_valid && req_ready;
   assign w_stall    = (r_state == c_S_HOLD) && !res_ready && !flush;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_accept) w_state_nxt = w_rm_legal ? c_S_ALIGN : c_S_HOLD;
         end
         c_S_ALIGN:   w_state_nxt = c_S_ADDNORM;
         c_S_ADDNORM: w_state_nxt = c_S_ROUND;
         c_S_ROUND:   w_state_nxt = c_S_HOLD;
         c_S_HOLD: begin
            if (res_ready) begin
               if (w_accept) w_state_nxt = w_rm_legal ? c_S_ALIGN : c_S_HOLD;
               else          w_state_nxt = c_S_IDLE;
            end
         end
         default:     w_state_nxt = c_S_IDLE;
      endcase
      if (flush) w_state_nxt = c_S_IDLE;
   end

   // Output decode. Enables and res_valid are suppressed in a flush cycle so
   // a killed op never updates a stage nor hands off a completion. req_ready
   // is also held low while reset is asserted so every output reads 0.
   always_comb begin
      align_en   = 1'b0;
      addnorm_en = 1'b0;
      round_en   = 1'b0;
      res_valid  = 1'b0;
      busy       = (r_state != c_S_IDLE);
      req_ready  = reset_n && !flush &&
                   ((r_state == c_S_IDLE) || ((r_state == c_S_HOLD) && res_ready));
      if (!flush) begin
         case (r_state)
            c_S_ALIGN:   align_en   = 1'b1;
            c_S_ADDNORM: addnorm_en = 1'b1;
            c_S_ROUND:   round_en   = 1'b1;
            c_S_HOLD:    res_valid  = 1'b1;
            default:     ;
         endcase
      end
   end

   // Per-op controls are captured only at accept, so CSR frm changes during
   // an op cannot disturb the round stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op_sub      <= 1'b0;
         r_rm_eff      <= 3'b000;
         r_res_tag     <= '0;
         r_res_illegal <= 1'b0;
      end else if (w_accept) begin
         r_op_sub      <= req_sub;
         r_rm_eff      <= w_rm_sel;
         r_res_tag     <= req_tag;
         r_res_illegal <= !w_rm_legal;
      end
   end

   assign op_sub      = r_op_sub;
   assign rm_eff      = r_rm_eff;
   assign res_tag     = r_res_tag;
   assign res_illegal = r_res_illegal;

   generate
      if (HOLD_TIMEOUT > 0) begin : g_timeout
         localparam int                 c_CNT_W = $clog2(HOLD_TIMEOUT + 1);
         localparam logic [c_CNT_W-1:0] c_TMO   = c_CNT_W'(HOLD_TIMEOUT);

         logic [c_CNT_W-1:0] r_hold_cnt;
         logic [c_CNT_W-1:0] w_cnt_nxt;
         logic               r_err;

         assign w_cnt_nxt = r_hold_cnt + 1'b1;

         // Counter saturates at the limit so the error fires only once per
         // stalled completion; any non-stall cycle restarts the count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_hold_cnt <= '0;
               r_err      <= 1'b0;
            end else begin
               r_err <= 1'b0;
               if (w_stall) begin
                  if (r_hold_cnt != c_TMO) begin
                     r_hold_cnt <= w_cnt_nxt;
                     r_err      <= (w_cnt_nxt == c_TMO);
                  end
               end else begin
                  r_hold_cnt <= '0;
               end
            end
         end

         assign err_timeout = r_err;
      end else begin : g_no_timeout
         assign err_timeout = 1'b0;
      end
   endgenerate

`ifdef FP_ADDSUB_PERF_EN
   logic [15:0] r_perf_ops;
   logic [15:0] r_perf_stall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_ops   <= 16'h0000;
         r_perf_stall <= 16'h0000;
      end else begin
         if ((r_state == c_S_HOLD) && res_ready && !flush && !r_res_illegal)
            r_perf_ops <= r_perf_ops + 16'h0001;
         if ((r_state == c_S_HOLD) && !res_ready)
            r_perf_stall <= r_perf_stall + 16'h0001;
      end
   end

   assign perf_ops   = r_perf_ops;
   assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_addsub_seq                                             |
// | Description : Self-checking bench for fp_addsub_seq. A transaction-level   |
// |               model (accept cycle + latency per op) predicts every output  |
// |               each cycle under directed and random stimulus.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fp_addsub_seq;
   localparam int TAG_W        = 5;
   localparam int HOLD_TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic             req_sub;
   logic [2:0]       req_rm;
   logic [TAG_W-1:0] req_tag;
   logic [2:0]       frm;
   logic             align_en, addnorm_en, round_en;
   logic             op_sub;
   logic [2:0]       rm_eff;
   logic             res_valid;
   logic             res_ready;
   logic [TAG_W-1:0] res_tag;
   logic             res_illegal;
   logic             busy;
   logic             err_timeout;
`ifdef FP_ADDSUB_PERF_EN
   logic [15:0]      perf_ops, perf_stall;
`endif

   always #5 clk = ~clk;

   fp_addsub_seq #(.TAG_W(TAG_W), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
      .req_rm(req_rm), .req_tag(req_tag), .frm(frm),
      .align_en(align_en), .addnorm_en(addnorm_en), .round_en(round_en),
      .op_sub(op_sub), .rm_eff(rm_eff),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
      .res_illegal(res_illegal), .busy(busy), .err_timeout(err_timeout)
`ifdef FP_ADDSUB_PERF_EN
      , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: at most one op owned by the sequencer, described by its accept
   // cycle and legality; its outputs follow from the fixed stage latency.
   bit               m_have;
   int               m_acc;
   bit               m_legal;
   logic             m_sub;
   logic [2:0]       m_rm;
   logic [TAG_W-1:0] m_tag;
   logic             m_ill;
   int               m_stall;
   bit               m_err_pend;
   logic [15:0]      m_pops, m_pstall;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_acc = 0; m_legal = 0;
      m_sub = 0; m_rm = 0; m_tag = 0; m_ill = 0;
      m_stall = 0; m_err_pend = 0; m_pops = 0; m_pstall = 0;
   endtask

   task automatic drive(input logic v, input logic s, input logic [2:0] rm,
                        input logic [TAG_W-1:0] t, input logic [2:0] f,
                        input logic rr, input logic fl);
      req_valid = v; req_sub = s; req_rm = rm; req_tag = t;
      frm = f; res_ready = rr; flush = fl;
   endtask

   // One clock cycle: check outputs mid-cycle, advance the model, clock.
   task automatic step();
      int   age;
      int   lat;
      bit   e_done, e_valid, e_ready;
      logic [2:0] rm_sel;
      @(negedge clk);
      lat     = m_legal ? 4 : 1;
      age     = cyc - m_acc;
      e_done  = m_have && (age >= lat);
      e_valid = e_done && !flush;
      e_ready = !flush && (!m_have || (e_done && res_ready));

      check_eq("align_en",   align_en,   m_have && m_legal && age == 1 && !flush);
      check_eq("addnorm_en", addnorm_en, m_have && m_legal && age == 2 && !flush);
      check_eq("round_en",   round_en,   m_have && m_legal && age == 3 && !flush);
      check_eq("res_valid",  res_valid,  e_valid);
      check_eq("req_ready",  req_ready,  e_ready);
      check_eq("busy",       busy,       m_have);
      check_eq("err_timeout", err_timeout, m_err_pend);
      check_eq("op_sub",     op_sub,     m_sub);
      check_eq("rm_eff",     rm_eff,     m_rm);
      check_eq("res_tag",    res_tag,    m_tag);
      check_eq("res_illegal", res_illegal, m_ill);
`ifdef FP_ADDSUB_PERF_EN
      check_eq("perf_ops",   perf_ops,   m_pops);
      check_eq("perf_stall", perf_stall, m_pstall);
`endif

      m_err_pend = 0;
      if (e_done && !res_ready) m_pstall++;
      if (e_valid && res_ready && m_legal) m_pops++;
      if (e_done && !res_ready && !flush) begin
         m_stall++;
         if (m_stall == HOLD_TIMEOUT) m_err_pend = 1;
      end else begin
         m_stall = 0;
      end
      if (flush || (e_valid && res_ready)) m_have = 0;
      if (req_valid && e_ready) begin
         rm_sel  = (req_rm == 3'b111) ? frm : req_rm;
         m_have  = 1;
         m_acc   = cyc;
         m_legal = (rm_sel <= 3'b100);
         m_sub   = req_sub;
         m_rm    = rm_sel;
         m_tag   = req_tag;
         m_ill   = !(rm_sel <= 3'b100);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 3'b000, '0, 3'b000, rr, 0);
         step();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ":align"},   align_en,   0);
      check_eq({tag, ":addnorm"}, addnorm_en, 0);
      check_eq({tag, ":round"},   round_en,   0);
      check_eq({tag, ":valid"},   res_valid,  0);
      check_eq({tag, ":ready"},   req_ready,  0);
      check_eq({tag, ":busy"},    busy,       0);
      check_eq({tag, ":err"},     err_timeout, 0);
      check_eq({tag, ":op_sub"},  op_sub,     0);
      check_eq({tag, ":rm_eff"},  rm_eff,     0);
      check_eq({tag, ":tag"},     res_tag,    0);
      check_eq({tag, ":ill"},     res_illegal, 0);
`ifdef FP_ADDSUB_PERF_EN
      check_eq({tag, ":pops"},    perf_ops,   0);
      check_eq({tag, ":pstall"},  perf_stall, 0);
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 3'b000, '0, 3'b000, 0, 0);
      model_reset();
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Plain add, RNE, writeback always ready
      drive(1, 0, 3'b000, 5'd5, 3'b010, 1, 0); step();
      idle(6, 1);

      // Dynamic rm from CSR; CSR changes two cycles in
      drive(1, 1, 3'b111, 5'd12, 3'b011, 1, 0); step();
      drive(0, 0, 3'b000, '0, 3'b011, 1, 0); step();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 3'b000, '0, 3'b000, 1, 0); step();
      end

      // Illegal static rm, then illegal resolved rm
      drive(1, 0, 3'b101, 5'd3, 3'b000, 1, 0); step();
      idle(3, 1);
      drive(1, 1, 3'b111, 5'd30, 3'b111, 1, 0); step();
      idle(3, 1);

      // Writeback stalls for 6 cycles, then drain with back-to-back accept
      drive(1, 1, 3'b010, 5'd7, 3'b000, 0, 0); step();
      idle(3, 0);
      idle(6, 0);
      drive(1, 0, 3'b001, 5'd9, 3'b000, 1, 0); step();
      idle(6, 1);

      // Flush while in ADDNORM
      drive(1, 0, 3'b100, 5'd17, 3'b000, 1, 0); step();
      idle(1, 1);
      drive(0, 0, 3'b000, '0, 3'b000, 1, 1); step();
      idle(6, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 1), 1'($urandom), 3'($urandom_range(0, 7)),
               TAG_W'($urandom), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
         step();
      end
      idle(8, 1);

      // Asynchronous reset while the op sits in ROUND
      drive(1, 1, 3'b011, 5'd21, 3'b000, 1, 0); step();
      idle(2, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(posedge clk);
      #1;
      cyc++;
      reset_n = 1'b1;
      drive(1, 0, 3'b000, 5'd1, 3'b000, 1, 0); step();
      idle(6, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle sequencer for the single-precision FP add/sub datapath (extract/align -> add/normalize -> round).
- Accepts one operation at a time from the FP issue logic over a valid/ready handshake.
- Resolves the effective rounding mode, drives the per-stage enables, and returns a tagged completion to writeback.
- Holds the completion until writeback accepts it.

Parameters:
TAG_W, 5, width of destination tag carried with each op
HOLD_TIMEOUT, 0, if >0: cycles in HOLD before err_timeout pulses (0 = disabled)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  pipeline kill; aborts in-flight op
req_valid  in  1  op request
req_ready  out  1  sequencer can accept
req_sub  in  1  1 = subtract, 0 = add
req_rm  in  3  instruction rm field
req_tag  in  TAG_W  destination tag
frm  in  3  CSR dynamic rounding mode
align_en  out  1  extract/align stage register enable
addnorm_en  out  1  add + normalize stage register enable
round_en  out  1  round stage / result register enable
op_sub  out  1  latched subtract control to datapath
rm_eff  out  3  latched effective rounding mode to round stage
res_valid  out  1  completion available
res_ready  in  1  writeback accepts completion
res_tag  out  TAG_W  tag of completed op
res_illegal  out  1  completion is an illegal-rm trap, no datapath result
busy  out  1  state != IDLE
err_timeout  out  1  one-cycle pulse, HOLD exceeded HOLD_TIMEOUT

Behaviour:
- Reset (reset_n low, async): state=IDLE. All outputs 0, including op_sub, rm_eff, res_tag and the counters.
- States: IDLE, ALIGN, ADDNORM, ROUND, HOLD.
- Accept = req_valid && req_ready.
- req_ready = !flush && (state==IDLE || (state==HOLD && res_ready)). Back-to-back accept is allowed in the HOLD drain cycle.
- rm resolution at accept:
  - rm_sel = (req_rm==3'b111) ? frm : req_rm.
  - Legal if rm_sel <= 3'b100; 101/110 illegal; 111 after resolution (frm==111) illegal.
- On accept: latch op_sub, rm_eff=rm_sel, res_tag.
  - Legal -> ALIGN.
  - Illegal -> HOLD with res_illegal=1; no stage enable is ever asserted for that op.
- ALIGN: align_en=1 for exactly this cycle -> ADDNORM.
- ADDNORM: addnorm_en=1 -> ROUND.
- ROUND: round_en=1 -> HOLD.
- Each stage enable is a Moore output, high exactly one cycle per legal op.
- Latency: accept in cycle N -> res_valid high in cycle N+4 (legal) or N+1 (illegal).
- HOLD:
  - res_valid=1; res_tag/res_illegal stable.
  - If res_ready: with a new accept -> ALIGN (or HOLD if illegal), else -> IDLE; res_valid deasserts the next cycle unless the new op is illegal.
  - If !res_ready: stay; res_valid and res_tag must not change.
- rm_eff and op_sub stay constant from accept until the next accept. frm changes mid-op have no effect.
- flush (synchronous, highest priority, any state) -> IDLE next cycle.
  - Enables are 0 in the flush cycle; res_valid drops; no completion is emitted for the killed op; req_ready=0 while flush is high.
- Flush and res_ready both high in HOLD: flush wins, and the completion counts as not delivered.
- Timeout: a counter increments each HOLD&&!res_ready cycle and clears on leaving HOLD. err_timeout pulses once when the count reaches HOLD_TIMEOUT; state is unaffected.
- Reset asserted mid-op: immediate IDLE. Datapath contents are don't-care.

Optional Feature:
FP_ADDSUB_PERF_EN:
- Defined: adds outputs perf_ops[15:0] and perf_stall[15:0].
  - perf_ops increments on each delivered legal completion (HOLD && res_ready && !flush && !res_illegal).
  - perf_stall increments on each HOLD && !res_ready cycle.
  - Both wrap at 16'hFFFF -> 0 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then add with req_rm=000, res_ready=1 held: align_en at N+1, addnorm_en at N+2, round_en at N+3, res_valid at N+4 for 1 cycle, rm_eff=000, tag echoed.
- req_rm=111, frm=011, then frm changed to 000 at N+2: rm_eff=011 throughout; completion at N+4.
- req_rm=101: res_valid at N+1 with res_illegal=1; align_en/addnorm_en/round_en never asserted. Repeat with req_rm=111, frm=111: same result.
- res_ready=0 for 6 cycles with HOLD_TIMEOUT=4: res_valid/res_tag stable; err_timeout pulses once after the 4th stall cycle; perf_stall=6 (if enabled). Then res_ready=1 with req_valid=1: new op accepted the same cycle, its align_en fires the next cycle.
- flush asserted in ADDNORM: round_en never fires, res_valid stays 0, busy=0 the next cycle, req_ready returns after flush drops.
- 65536 legal ops with FP_ADDSUB_PERF_EN: perf_ops wraps to 0; reset_n pulsed low mid-ROUND: all outputs 0 immediately.
